// File: rtl/msg_recorder.sv
// Serial message recorder: buffers received UART characters and replays them.
// Define MSG_RECORDER_ECHO_EN to also echo each accepted character at once.

module msg_recorder #(
    parameter int DATA_W       = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  serial_in,
    input  logic                  btn_play,
    input  logic                  btn_clear,
    output logic                  serial_out,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [IW-1:0] FULL      = IW'(DEPTH);

    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_LOAD, T_START, T_DATA, T_STOP
    } tx_state_t;

    logic rx_m, rx_s, rx_prev, play_q, clr_q;
    logic rx_fall, play_edge, clr_edge;

    rx_state_t         r_st, r_nx;
    logic [CW-1:0]     r_cnt, r_cnt_nx;
    logic [BW-1:0]     r_bit, r_bit_nx;
    logic [DATA_W-1:0] r_sh, r_sh_nx;
    logic              wr_pend, wr_pend_nx;
    logic              stop_q, stop_nx;

    tx_state_t         t_st, t_nx;
    logic [CW-1:0]     t_cnt, t_cnt_nx;
    logic [BW-1:0]     t_bit, t_bit_nx;
    logic [DATA_W-1:0] t_sh, t_sh_nx;
    logic [IW-1:0]     rd_idx, rd_idx_nx, rd_next;
    logic              busy_nx, so_nx;

    logic              clr_go, play_go, echo_go, wr_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            play_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            rx_m    <= serial_in;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            play_q  <= btn_play;
            clr_q   <= btn_clear;
        end
    end

    assign rx_fall   = rx_prev & ~rx_s;
    assign play_edge = btn_play & ~play_q;
    assign clr_edge  = btn_clear & ~clr_q;

    assign clr_go  = clr_edge && active && !busy;
    assign wr_ok   = wr_pend && active && !clr_go
                     && stop_q && (count != FULL);
    assign play_go = play_edge && !clr_edge && active && !busy
                     && (count != '0) && (r_st == R_IDLE)
                     && (t_st == T_IDLE);
`ifdef MSG_RECORDER_ECHO_EN
    assign echo_go = wr_ok && (t_st == T_IDLE) && !play_go;
`else
    assign echo_go = 1'b0;
`endif

    always_comb begin
        r_nx       = r_st;
        r_cnt_nx   = r_cnt;
        r_bit_nx   = r_bit;
        r_sh_nx    = r_sh;
        wr_pend_nx = 1'b0;
        stop_nx    = stop_q;
        if (!active) begin
            r_nx     = R_IDLE;
            r_cnt_nx = '0;
        end else begin
            unique case (r_st)
                R_IDLE: begin
                    if (rx_fall && !busy) begin
                        r_nx     = R_START;
                        r_cnt_nx = '0;
                    end
                end
                R_START: begin
                    if (r_cnt == BAUD_MID) begin
                        r_cnt_nx = '0;
                        r_bit_nx = '0;
                        r_nx     = rx_s ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt_nx = r_cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (r_cnt == BAUD_LAST) begin
                        r_cnt_nx = '0;
                        r_sh_nx  = {rx_s, r_sh[DATA_W-1:1]};
                        if (r_bit == BIT_LAST)
                            r_nx = R_STOP;
                        else
                            r_bit_nx = r_bit + BW'(1);
                    end else begin
                        r_cnt_nx = r_cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (r_cnt == BAUD_LAST) begin
                        r_cnt_nx   = '0;
                        wr_pend_nx = 1'b1;
                        stop_nx    = rx_s;
                        r_nx       = R_IDLE;
                    end else begin
                        r_cnt_nx = r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_st    <= R_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            wr_pend <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            r_st    <= r_nx;
            r_cnt   <= r_cnt_nx;
            r_bit   <= r_bit_nx;
            r_sh    <= r_sh_nx;
            wr_pend <= wr_pend_nx;
            stop_q  <= stop_nx;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (clr_go) begin
            count     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (wr_pend && active) begin
            if (!stop_q)
                frame_err <= 1'b1;
            else if (count == FULL)
                overflow <= 1'b1;
            else
                count <= count + IW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (wr_ok)
            mem[count[DEPTH_LOG2-1:0]] <= r_sh;
    end

    assign rd_next = rd_idx + IW'(1);

    always_comb begin
        t_nx      = t_st;
        t_cnt_nx  = t_cnt;
        t_bit_nx  = t_bit;
        t_sh_nx   = t_sh;
        rd_idx_nx = rd_idx;
        busy_nx   = busy;
        if (!active) begin
            t_nx     = T_IDLE;
            t_cnt_nx = '0;
            busy_nx  = 1'b0;
        end else begin
            unique case (t_st)
                T_IDLE: begin
                    if (play_go) begin
                        t_nx      = T_LOAD;
                        busy_nx   = 1'b1;
                        rd_idx_nx = '0;
                    end else if (echo_go) begin
                        t_nx     = T_START;
                        t_sh_nx  = r_sh;
                        t_cnt_nx = '0;
                    end
                end
                T_LOAD: begin
                    t_sh_nx  = mem[rd_idx[DEPTH_LOG2-1:0]];
                    t_cnt_nx = '0;
                    t_nx     = T_START;
                end
                T_START: begin
                    if (t_cnt == BAUD_LAST) begin
                        t_cnt_nx = '0;
                        t_bit_nx = '0;
                        t_nx     = T_DATA;
                    end else begin
                        t_cnt_nx = t_cnt + CW'(1);
                    end
                end
                T_DATA: begin
                    if (t_cnt == BAUD_LAST) begin
                        t_cnt_nx = '0;
                        t_sh_nx  = t_sh >> 1;
                        if (t_bit == BIT_LAST)
                            t_nx = T_STOP;
                        else
                            t_bit_nx = t_bit + BW'(1);
                    end else begin
                        t_cnt_nx = t_cnt + CW'(1);
                    end
                end
                T_STOP: begin
                    if (t_cnt == BAUD_LAST) begin
                        t_cnt_nx = '0;
                        // chain the next character with no idle gap
                        if (busy && (rd_next < count)) begin
                            rd_idx_nx = rd_next;
                            t_sh_nx   = mem[rd_next[DEPTH_LOG2-1:0]];
                            t_nx      = T_START;
                        end else begin
                            t_nx    = T_IDLE;
                            busy_nx = 1'b0;
                        end
                    end else begin
                        t_cnt_nx = t_cnt + CW'(1);
                    end
                end
                default: t_nx = T_IDLE;
            endcase
        end
        so_nx = (t_nx == T_START) ? 1'b0
              : (t_nx == T_DATA)  ? t_sh_nx[0]
              : 1'b1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            t_st       <= T_IDLE;
            t_cnt      <= '0;
            t_bit      <= '0;
            t_sh       <= '0;
            rd_idx     <= '0;
            busy       <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            t_st       <= t_nx;
            t_cnt      <= t_cnt_nx;
            t_bit      <= t_bit_nx;
            t_sh       <= t_sh_nx;
            rd_idx     <= rd_idx_nx;
            busy       <= busy_nx;
            serial_out <= so_nx;
        end
    end

endmodule

// File: doc/msg_recorder.md
MSG_RECORDER -- requirements
Module: msg_recorder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning the buffer holds 2^DEPTH_LOG2 characters.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 5208, meaning sysclk cycles per serial bit (must be >= 4).
REQ-004 SHALL have the port sysclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have the port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have the port active  input  1  block enable; low = idle and hold.
REQ-007 SHALL have the port serial_in  input  1  asynchronous serial receive line, idle high.
REQ-008 SHALL have the port btn_play  input  1  debounced level; a rising edge requests replay.
REQ-009 SHALL have the port btn_clear  input  1  debounced level; a rising edge empties the buffer.
REQ-010 SHALL have the port serial_out  output  1  serial transmit line, idle high.
REQ-011 SHALL have the port busy  output  1  high while replay is in progress.
REQ-012 SHALL have the port count  output  DEPTH_LOG2+1  number of stored characters.
REQ-013 SHALL have the port overflow  output  1  sticky flag: a character was dropped because the buffer was full.
REQ-014 SHALL have the port frame_err  output  1  sticky flag: a bad stop bit was seen.

Function
REQ-015 SHALL pass serial_in through a 2-flop synchroniser; all receive decisions use the synchronised value.
REQ-016 SHALL use receive FSM R_IDLE->R_START->R_DATA->R_STOP->R_IDLE, with one baud counter that counts 0..CLKS_PER_BIT-1.
REQ-017 SHALL move R_IDLE->R_START on a synchronised high-to-low transition, only while active=1 and busy=0.
REQ-018 SHALL resample in R_START at count CLKS_PER_BIT/2 (integer division); if the line is high there, treat it as a glitch and return to R_IDLE without writing.
REQ-019 SHALL sample DATA_W data bits LSB-first, each CLKS_PER_BIT cycles after the previous sample, then sample the stop bit.
REQ-020 SHALL write the character at address count and increment count, one cycle after stop-bit sampling, when the stop bit=1 and count<2^DEPTH_LOG2.
REQ-021 SHALL discard the character and set frame_err when the stop bit=0; SHALL discard the character and set overflow when the stop bit=1 and count=2^DEPTH_LOG2; count SHALL be unchanged in both cases.
REQ-022 SHALL use transmit FSM T_IDLE->T_LOAD->T_START->T_DATA->T_STOP, each bit held for exactly CLKS_PER_BIT cycles, LSB first, with stop bit=1.
REQ-023 SHALL start replay on a btn_play rising edge when count>0, the receive FSM is in R_IDLE, and active=1: busy rises the next cycle, and characters 0..count-1 are sent back-to-back; otherwise the edge is ignored.
REQ-024 SHALL drop busy in the cycle after the last stop bit completes; count SHALL be unchanged by replay.
REQ-025 SHALL, on a btn_clear rising edge while busy=0, set count, overflow and frame_err to 0 the next cycle; SHALL ignore btn_clear while busy=1.
REQ-026 SHALL give btn_clear priority when a btn_clear edge and a btn_play edge arrive in the same cycle; the play edge is then ignored.
REQ-027 SHALL, when active falls mid-operation, abort both FSMs to idle within one cycle and drive serial_out=1 and busy=0; stored contents and count SHALL be retained, and any partial character SHALL be discarded.
REQ-028 SHALL hold serial_out=1 whenever the transmit FSM is in T_IDLE.

Reset
REQ-029 SHALL, while reset=0: serial_out=1, busy=0, count=0, overflow=0, frame_err=0, both FSMs in idle, synchroniser and edge-detect flops at 1/0 (line idle / buttons released); buffer RAM contents are not reset.
REQ-030 SHALL resume operation on the first sysclk edge after reset deasserts, with no spurious button edge detected.

Configuration
REQ-031 SHALL support the macro MSG_RECORDER_ECHO_EN; when defined, each accepted character (REQ-020) is also transmitted immediately if the transmit FSM is in T_IDLE, with busy staying 0 during the echo; if the transmitter is busy, the echo is dropped; btn_play edges during an echo are ignored.
REQ-032 SHALL NOT echo when MSG_RECORDER_ECHO_EN is undefined; serial_out then toggles only during replay.

Verification (bench uses CLKS_PER_BIT=4, DATA_W=8, DEPTH_LOG2=2)
REQ-033 SHALL cover: receive 0x48, 0x69 with good stop bits, then pulse btn_play -> count=2, busy high, serial_out carries 0x48 then 0x69 at 4 clocks/bit, busy low afterwards.
REQ-034 SHALL cover: receive 5 characters 0x41..0x45 -> count=4, overflow=1, and replay emits 0x41..0x44 only.
REQ-035 SHALL cover: receive 0x55 with stop bit=0 -> frame_err=1, count unchanged; then pulse btn_clear -> count=0 and frame_err=0.
REQ-036 SHALL cover: a 1-clock low glitch on serial_in -> no write, count unchanged, receive FSM back in R_IDLE.
REQ-037 SHALL cover: active driven low during the 2nd replayed character -> serial_out=1 and busy=0 within 1 clock, count still 2.
REQ-038 SHALL cover: with MSG_RECORDER_ECHO_EN defined, receive 0x7A -> serial_out retransmits 0x7A starting 1-2 clocks after stop-bit sampling, with busy=0 throughout.
